// File: rtl/dmem_pkg.sv
// Shared types and constants for the mini_rv data-memory responder.
// Counter logic is present only when DMEM_ACCESS_CNT_EN is defined.
package dmem_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WAIT   = 2'd1,
    S_ACCESS = 2'd2,
    S_RESP   = 2'd3
  } state_e;

  localparam int NUM_LANES = 4;
  localparam logic [NUM_LANES-1:0] WSTRB_WORD = 4'hF;
  localparam int CNT_W = 16;

  function automatic logic [CNT_W-1:0] sat_inc(
    input logic [CNT_W-1:0] v
  );
    return (&v) ? v : v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/dmem_storage.sv
// Word RAM with per-lane write enables and a registered read port.
// Contents are never reset; the read register only moves on re_i.
module dmem_storage
  import dmem_pkg::*;
#(
  parameter int ADDR_W = 14
) (
  input  logic                 clk_i,
  input  logic                 we_i,
  input  logic                 re_i,
  input  logic [ADDR_W-1:0]    addr_i,
  input  logic [NUM_LANES-1:0] be_i,
  input  logic [31:0]          wdata_i,
  output logic [31:0]          rdata_o
);

  logic [31:0] mem_q [2**ADDR_W];
  logic [31:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int i = 0; i < NUM_LANES; i++) begin
        if (be_i[i]) begin
          mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
        end
      end
    end
    if (re_i) begin
      rdata_q <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Handshaked single-outstanding data-memory responder with wait states.
// Optional access counters are built when DMEM_ACCESS_CNT_EN is defined.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int ADDR_W      = 14,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_we,
  input  logic [31:0]          req_addr,
  input  logic [31:0]          req_wdata,
  input  logic [NUM_LANES-1:0] req_wstrb,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic [31:0]          resp_rdata,
  output logic                 resp_err,
  output logic [CNT_W-1:0]     cnt_rd,
  output logic [CNT_W-1:0]     cnt_wr,
  output logic [CNT_W-1:0]     cnt_err
);

  localparam int WCW =
    (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;

  state_e               state_q;
  logic [WCW-1:0]       wcnt_q;
  logic                 lat_we_q;
  logic [31:0]          lat_addr_q;
  logic [31:0]          lat_wdata_q;
  logic [NUM_LANES-1:0] lat_wstrb_q;
  logic                 req_ready_q;
  logic                 resp_valid_q;
  logic                 resp_err_q;
  logic                 rd_sel_q;

  logic        err;
  logic        in_access;
  logic        ram_we;
  logic        ram_re;
  logic [31:0] ram_rdata;

  assign err = (lat_addr_q[1:0] != 2'b00)
             | ((lat_addr_q >> (ADDR_W + 2)) != 32'd0)
             | (lat_we_q & (lat_wstrb_q == '0));

  assign in_access = (state_q == S_ACCESS);
  assign ram_we    = in_access & lat_we_q & ~err;
  assign ram_re    = in_access & ~lat_we_q & ~err;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      wcnt_q       <= '0;
      lat_we_q     <= 1'b0;
      lat_addr_q   <= '0;
      lat_wdata_q  <= '0;
      lat_wstrb_q  <= '0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      rd_sel_q     <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (req_valid && req_ready_q) begin
            lat_we_q    <= req_we;
            lat_addr_q  <= req_addr;
            lat_wdata_q <= req_wdata;
            lat_wstrb_q <= req_wstrb;
            req_ready_q <= 1'b0;
            if (WAIT_CYCLES > 0) begin
              state_q <= S_WAIT;
              wcnt_q  <= WCW'(1);
            end else begin
              state_q <= S_ACCESS;
            end
          end
        end
        S_WAIT: begin
          if (wcnt_q == WCW'(WAIT_CYCLES)) begin
            wcnt_q  <= '0;
            state_q <= S_ACCESS;
          end else begin
            wcnt_q <= wcnt_q + WCW'(1);
          end
        end
        S_ACCESS: begin
          resp_valid_q <= 1'b1;
          resp_err_q   <= err;
          rd_sel_q     <= ~lat_we_q & ~err;
          state_q      <= S_RESP;
        end
        S_RESP: begin
          if (resp_ready) begin
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            rd_sel_q     <= 1'b0;
            req_ready_q  <= 1'b1;
            state_q      <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Read data lives in the RAM output register; masked outside a good load.
  dmem_storage #(
    .ADDR_W (ADDR_W)
  ) u_storage (
    .clk_i   (clk),
    .we_i    (ram_we),
    .re_i    (ram_re),
    .addr_i  (lat_addr_q[ADDR_W+1:2]),
    .be_i    (lat_wstrb_q),
    .wdata_i (lat_wdata_q),
    .rdata_o (ram_rdata)
  );

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_err   = resp_err_q;
  assign resp_rdata = rd_sel_q ? ram_rdata : 32'd0;

`ifdef DMEM_ACCESS_CNT_EN
  logic [CNT_W-1:0] cnt_rd_q;
  logic [CNT_W-1:0] cnt_wr_q;
  logic [CNT_W-1:0] cnt_err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_rd_q  <= '0;
      cnt_wr_q  <= '0;
      cnt_err_q <= '0;
    end else if (in_access) begin
      if (err) begin
        cnt_err_q <= sat_inc(cnt_err_q);
      end else if (lat_we_q) begin
        cnt_wr_q <= sat_inc(cnt_wr_q);
      end else begin
        cnt_rd_q <= sat_inc(cnt_rd_q);
      end
    end
  end

  assign cnt_rd  = cnt_rd_q;
  assign cnt_wr  = cnt_wr_q;
  assign cnt_err = cnt_err_q;
`else
  assign cnt_rd  = '0;
  assign cnt_wr  = '0;
  assign cnt_err = '0;
`endif

endmodule
